// File: rtl/setup_input_sequencer_pkg.sv
// Shared encodings for the Setup input sequencer: Setup block Cmd values,
// sequencer state encoding and the per-state status flag decode.
package setup_input_sequencer_pkg;

   // Setup block Cmd encodings seen on SetupCmd
   localparam int SetupStatesWidth = 3;
   localparam logic [SetupStatesWidth-1:0] St_Idle            = 3'd0;
   localparam logic [SetupStatesWidth-1:0] St_Header          = 3'd1;
   localparam logic [SetupStatesWidth-1:0] St_InputEncryption = 3'd2;
   localparam logic [SetupStatesWidth-1:0] St_Execute         = 3'd3;

   // Sequencer controller states
   localparam int SqStatesWidth = 3;
   typedef enum logic [SqStatesWidth-1:0] {
      Sq_Idle  = 3'd0,
      Sq_Armed = 3'd1,
      Sq_Serve = 3'd2,
      Sq_Done  = 3'd3,
      Sq_Err   = 3'd4
   } sq_state_t;

   // Host-visible status levels, registered alongside the state
   typedef struct packed {
      logic ready;
      logic busy;
      logic done;
      logic error;
   } sq_flags_t;

   // Status levels that hold while the controller sits in state s
   function automatic sq_flags_t sq_flags(input sq_state_t s);
      sq_flags_t f;
      f.ready = (s == Sq_Idle);
      f.busy  = (s == Sq_Armed) || (s == Sq_Serve);
      f.done  = (s == Sq_Done);
      f.error = (s == Sq_Err);
      return f;
   endfunction

endpackage

// File: rtl/input_buffer_ram.sv
// Input word buffer: one write port, one read port with a registered output.
// The read register is what gives the sequencer its one-cycle response latency;
// it only updates on a read so the response word holds between requests.
module input_buffer_ram #(
   parameter int DataWidth = 128,
   parameter int Depth     = 16,
   parameter int AddrWidth = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [DataWidth-1:0] wdata,
   input  logic                 re,
   input  logic [AddrWidth-1:0] raddr,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [Depth];

   // Storage write; contents deliberately survive reset
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read, cleared by reset so the response bus starts at zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/setup_input_sequencer.sv
// Host-side sequencer for the Setup block input handshake: answers the header
// request with the input count, then each index request with the buffered word,
// and reports done once Setup moves to execute.
module setup_input_sequencer
   import setup_input_sequencer_pkg::*;
#(
   parameter int DataWidth      = 128,
   parameter int MaxInputLength = 16,
   parameter int IdxWidth       = $clog2(MaxInputLength + 1)
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        LoadValid,
   output logic                        LoadReady,
   input  logic [IdxWidth-1:0]         LoadIndex,
   input  logic [DataWidth-1:0]        LoadData,
   input  logic                        Start,
   input  logic [IdxWidth-1:0]         StartLength,
   input  logic                        Clear,
   input  logic [SetupStatesWidth-1:0] SetupCmd,
   input  logic [DataWidth-1:0]        SetupDataOut,
   input  logic                        SetupOutValid,
   output logic [DataWidth-1:0]        SetupDataIn,
   output logic                        SetupInValid,
   output logic                        Busy,
   output logic                        Done,
   output logic                        Error,
   output logic [IdxWidth-1:0]         ServedCount
);

   localparam int AddrWidth = (MaxInputLength > 1) ? $clog2(MaxInputLength) : 1;
   localparam logic [IdxWidth-1:0] MaxLen = IdxWidth'(MaxInputLength);

   sq_state_t            state;
   sq_flags_t            flags;
   logic [IdxWidth-1:0]  len;
   logic [IdxWidth-1:0]  served;
   logic                 resp_vld;
   logic                 resp_from_ram;
   logic [DataWidth-1:0] hdr_word;
   logic [DataWidth-1:0] ram_rdata;

   logic                 hdr_req, idx_req, exec_req, idx_ok, len_ok;
   logic                 buf_we, buf_re;
   logic [IdxWidth-1:0]  req_idx;

   assign hdr_req  = SetupOutValid && (SetupCmd == St_Header);
   assign idx_req  = SetupOutValid && (SetupCmd == St_InputEncryption);
   assign exec_req = (SetupCmd == St_Execute);
   assign req_idx  = SetupDataOut[IdxWidth-1:0];
   // Any nonzero upper bit makes the index out of range regardless of low bits
   assign idx_ok   = (SetupDataOut[DataWidth-1:IdxWidth] == '0) && (req_idx < len);
   assign len_ok   = (StartLength != '0) && (StartLength <= MaxLen);

   assign buf_we   = (state == Sq_Idle) && LoadValid && (LoadIndex < MaxLen);
   assign buf_re   = (state == Sq_Serve) && idx_req && idx_ok;

   input_buffer_ram #(
      .DataWidth (DataWidth),
      .Depth     (MaxInputLength),
      .AddrWidth (AddrWidth)
   ) u_buf (
      .clock (Clock),
      .reset (Reset),
      .we    (buf_we),
      .waddr (LoadIndex[AddrWidth-1:0]),
      .wdata (LoadData),
      .re    (buf_re),
      .raddr (req_idx[AddrWidth-1:0]),
      .rdata (ram_rdata)
   );

   // Controller FSM with response pulse, header word, count and status flags
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state         <= Sq_Idle;
         flags         <= sq_flags(Sq_Idle);
         len           <= '0;
         served        <= '0;
         resp_vld      <= 1'b0;
         resp_from_ram <= 1'b0;
         hdr_word      <= '0;
      end else begin
         resp_vld <= 1'b0;
         case (state)
            Sq_Idle: begin
               if (Start) begin
                  if (len_ok) begin
                     len    <= StartLength;
                     served <= '0;
                     state  <= Sq_Armed;
                     flags  <= sq_flags(Sq_Armed);
                  end else begin
                     state  <= Sq_Err;
                     flags  <= sq_flags(Sq_Err);
                  end
               end
            end
            Sq_Armed: begin
               if (hdr_req) begin
                  resp_vld      <= 1'b1;
                  resp_from_ram <= 1'b0;
                  hdr_word      <= {{(DataWidth-IdxWidth){1'b0}}, len};
                  state         <= Sq_Serve;
                  flags         <= sq_flags(Sq_Serve);
               end
            end
            Sq_Serve: begin
               if (idx_req) begin
                  if (idx_ok) begin
                     resp_vld      <= 1'b1;
                     resp_from_ram <= 1'b1;
                     if (served < len) served <= served + 1'b1;
                  end else begin
                     state <= Sq_Err;
                     flags <= sq_flags(Sq_Err);
                  end
               end else if (exec_req) begin
                  state <= Sq_Done;
                  flags <= sq_flags(Sq_Done);
               end
            end
            Sq_Done, Sq_Err: begin
               if (Clear) begin
                  state <= Sq_Idle;
                  flags <= sq_flags(Sq_Idle);
               end
            end
            default: begin
               state <= Sq_Idle;
               flags <= sq_flags(Sq_Idle);
            end
         endcase
      end
   end

   // Both response sources are registers, so the bus holds between pulses
   assign SetupDataIn  = resp_from_ram ? ram_rdata : hdr_word;
   assign SetupInValid = resp_vld;
   assign LoadReady    = flags.ready;
   assign Busy         = flags.busy;
   assign Done         = flags.done;
   assign Error        = flags.error;
   assign ServedCount  = served;

endmodule

// File: tb/tb_setup_input_sequencer.sv
// Bench for setup_input_sequencer: plays the Setup block, keeps a behavioural
// model of the host-visible contract and scoreboards every response pulse.
module tb_setup_input_sequencer;
   import setup_input_sequencer_pkg::*;

   localparam int DW = 128;
   localparam int ML = 16;
   localparam int IW = $clog2(ML + 1);

   localparam int P_IDLE = 0, P_ARMED = 1, P_SERVE = 2, P_DONE = 3, P_ERR = 4;

   logic                        Clock = 1'b0;
   logic                        Reset;
   logic                        LoadValid, LoadReady, Start, Clear;
   logic [IW-1:0]               LoadIndex, StartLength, ServedCount;
   logic [DW-1:0]               LoadData, SetupDataOut, SetupDataIn;
   logic [SetupStatesWidth-1:0] SetupCmd;
   logic                        SetupOutValid, SetupInValid, Busy, Done, Error;

   setup_input_sequencer #(.DataWidth(DW), .MaxInputLength(ML)) dut (
      .Clock(Clock), .Reset(Reset),
      .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadIndex(LoadIndex), .LoadData(LoadData),
      .Start(Start), .StartLength(StartLength), .Clear(Clear),
      .SetupCmd(SetupCmd), .SetupDataOut(SetupDataOut), .SetupOutValid(SetupOutValid),
      .SetupDataIn(SetupDataIn), .SetupInValid(SetupInValid),
      .Busy(Busy), .Done(Done), .Error(Error), .ServedCount(ServedCount)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc = cyc + 1;

   // Reference model: buffer image, armed length, delivered count, phase
   logic [DW-1:0] m_buf [ML];
   int m_len = 0, m_served = 0, phase = P_IDLE;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;
   exp_t exp_q [$];

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic load(input int idx, input logic [DW-1:0] d);
      LoadValid = 1'b1; LoadIndex = IW'(idx); LoadData = d;
      if (phase == P_IDLE && idx < ML) m_buf[idx] = d;
      tick();
      LoadValid = 1'b0;
   endtask

   task automatic start(input int len);
      Start = 1'b1; StartLength = IW'(len);
      if (phase == P_IDLE) begin
         if (len >= 1 && len <= ML) begin
            m_len = len; m_served = 0; phase = P_ARMED;
         end else phase = P_ERR;
      end
      tick();
      Start = 1'b0;
   endtask

   task automatic clear();
      Clear = 1'b1;
      if (phase == P_DONE || phase == P_ERR) phase = P_IDLE;
      tick();
      Clear = 1'b0;
   endtask

   task automatic header();
      SetupCmd = St_Header; SetupOutValid = 1'b1; SetupDataOut = rnd128();
      if (phase == P_ARMED) begin
         exp_q.push_back('{data: DW'(m_len), cyc: cyc + 1});
         phase = P_SERVE;
      end
      tick();
      SetupOutValid = 1'b0; SetupCmd = St_Idle;
   endtask

   // drop: a reset follows immediately, so no response is expected
   task automatic index(input logic [DW-1:0] v, input bit drop);
      SetupCmd = St_InputEncryption; SetupOutValid = 1'b1; SetupDataOut = v;
      if (phase == P_SERVE) begin
         if (v < DW'(m_len)) begin
            if (!drop) exp_q.push_back('{data: m_buf[int'(v[7:0])], cyc: cyc + 1});
            if (m_served < m_len) m_served++;
         end else phase = P_ERR;
      end
      tick();
      SetupOutValid = 1'b0; SetupCmd = St_Idle;
   endtask

   task automatic execute();
      SetupCmd = St_Execute;
      if (phase == P_SERVE) phase = P_DONE;
      tick();
      SetupCmd = St_Idle;
   endtask

   task automatic check_status(input string tag);
      chk({tag, ":Busy"},        DW'(Busy),        DW'(phase == P_ARMED || phase == P_SERVE));
      chk({tag, ":Done"},        DW'(Done),        DW'(phase == P_DONE));
      chk({tag, ":Error"},       DW'(Error),       DW'(phase == P_ERR));
      chk({tag, ":LoadReady"},   DW'(LoadReady),   DW'(phase == P_IDLE));
      chk({tag, ":ServedCount"}, DW'(ServedCount), DW'(m_served));
   endtask

   initial begin
      exp_t e;
      int len, nreq;
      logic [DW-1:0] v;

      Reset = 1'b1; LoadValid = 1'b0; LoadIndex = '0; LoadData = '0;
      Start = 1'b0; StartLength = '0; Clear = 1'b0;
      SetupCmd = St_Idle; SetupDataOut = '0; SetupOutValid = 1'b0;

      // Response monitor: every pulse must match the head of the scoreboard
      fork
         forever begin
            @(negedge Clock);
            if (Reset) begin
               chk("inval_in_reset", DW'(SetupInValid), '0);
            end else if (SetupInValid) begin
               if (exp_q.size() == 0) chk("unexpected_resp", DW'(SetupInValid), '0);
               else begin
                  e = exp_q.pop_front();
                  chk("resp_data", SetupDataIn, e.data);
                  chk("resp_cycle", DW'(cyc), DW'(e.cyc));
               end
            end
         end
      join_none

      // Reset values
      tick(); tick();
      chk("rst:SetupDataIn", SetupDataIn, '0);
      check_status("rst");
      Reset = 1'b0;
      tick();

      // 1. Normal run
      load(0, 128'h00112233_44556677_8899aabb_ccddeeff);
      load(1, 128'd1);
      load(2, 128'd19);
      start(3); check_status("t1_armed");
      tick(); header(); tick();
      for (int k = 0; k < 3; k++) begin index(DW'(k), 1'b0); tick(); end
      execute(); check_status("t1_done");
      clear(); check_status("t1_clear");

      // 2. Illegal lengths
      start(0);  check_status("t2_len0");
      clear();   check_status("t2_clr0");
      start(17); check_status("t2_len17");
      clear();   check_status("t2_clr17");

      // 3. Out-of-range index with Len=3
      for (int i = 0; i < ML; i++) load(i, rnd128());
      start(3); header(); tick();
      index(DW'(5), 1'b0); check_status("t3_err");
      tick(); tick();
      chk("t3_no_pending", DW'(exp_q.size()), '0);
      clear();

      // 4. Reset the cycle after an index request
      start(4); header(); tick();
      index(DW'(2), 1'b1);
      Reset = 1'b1;
      phase = P_IDLE; m_served = 0; exp_q.delete();
      #2;
      chk("t4:SetupInValid", DW'(SetupInValid), '0);
      chk("t4:SetupDataIn", SetupDataIn, '0);
      check_status("t4_rst");
      tick();
      Reset = 1'b0;
      tick();
      start(4); header(); tick();
      index(DW'(2), 1'b0); tick();
      execute(); check_status("t4_done"); clear();

      // 5. Load and Start ignored while serving
      start(4); header(); tick();
      index(DW'(1), 1'b0);
      load(0, rnd128());
      start(7); check_status("t5_serve");
      index(DW'(0), 1'b0); tick();
      execute(); check_status("t5_done"); clear();

      // 6. Repeated index, count saturates at Len
      start(2); header(); tick();
      for (int k = 0; k < 3; k++) begin index(DW'(1), 1'b0); tick(); end
      check_status("t6_sat");
      execute(); check_status("t6_done"); clear();

      // Randomized sessions
      for (int it = 0; it < 25; it++) begin
         repeat ($urandom_range(0, 4)) load($urandom_range(0, 31), rnd128());
         if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1) ? 0 : $urandom_range(17, 31);
         else len = $urandom_range(1, 16);
         start(len); check_status("rnd_start");
         if (phase == P_ARMED) begin
            gap(); header();
            nreq = $urandom_range(1, 20);
            for (int k = 0; k < nreq; k++) begin
               if (phase != P_SERVE) break;
               gap();
               case ($urandom_range(0, 19))
                  0:       v = rnd128();
                  1:       v = DW'($urandom_range(len, 31));
                  default: v = DW'($urandom_range(0, len - 1));
               endcase
               index(v, 1'b0);
            end
            tick();
            if (phase == P_SERVE) execute();
         end
         check_status("rnd_end");
         tick();
         clear(); check_status("rnd_clear");
      end

      tick(); tick(); tick();
      chk("queue_drained", DW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
